// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Holds request and FIFO-entry structs, grant FSM states and field widths.
package rf_wb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic    live;
        wb_req_t req;
    } wb_ent_t;

    typedef enum logic {
        GNT_PIPE = 1'b0,
        GNT_LLU  = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular queue of LLU writeback entries with a kill-by-address port.
// Ports: clk, rst_n (async, active-low); push/push_ent enqueue; pop dequeues
// head; empty/full status; kill_en/kill_addr clear live on matching entries.
// Optional (RF_WB_PENDMASK_EN): pend_mask, one bit per register with a
// live queued write (bit 0 always 0).
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  wb_ent_t           push_ent,
    input  logic              pop,
    output wb_ent_t           head,
    output logic              empty,
    output logic              full,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_addr
`ifdef RF_WB_PENDMASK_EN
    ,
    output logic [31:0]       pend_mask
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_ent_t        mem [DEPTH];
    logic [PW-1:0]  rptr;
    logic [PW-1:0]  wptr;
    logic [CW-1:0]  count;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Popped slots get live cleared so a stale slot never looks pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].req.addr == kill_addr) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop_ok) begin
                mem[rptr].live <= 1'b0;
                rptr           <= rptr + PW'(1);
            end
            if (push_ok) begin
                mem[wptr] <= push_ent;
                wptr      <= wptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RF_WB_PENDMASK_EN
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) begin
                pend_mask[mem[i].req.addr] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between PIPE writeback and LLU results.
// Ports: clk, rst_n; p_valid/p_ready/p_addr/p_data (PIPE, priority);
// l_valid/l_ready/l_addr/l_data (LLU, queued); RegWEn/AddrD/DataD (registered
// write port). Optional (RF_WB_PENDMASK_EN): PendMask of live queued targets.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [REG_AW-1:0] p_addr,
    input  logic [REG_DW-1:0] p_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [REG_AW-1:0] l_addr,
    input  logic [REG_DW-1:0] l_data,
    output logic              RegWEn,
    output logic [REG_AW-1:0] AddrD,
    output logic [REG_DW-1:0] DataD
`ifdef RF_WB_PENDMASK_EN
    ,
    output logic [31:0]       PendMask
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    gnt_state_e    state;
    logic [SW-1:0] starve_cnt;

    logic          empty;
    logic          full;
    wb_ent_t       head;
    wb_ent_t       push_ent;
    wb_ent_t       gnt;
    logic          p_fire;
    logic          l_fire;
    logic          pop;
    logic          kill_en;
    logic          gnt_valid;
    logic          we_nxt;
    logic          lose;

    assign p_ready = rst_n && (state == GNT_PIPE);
    assign l_ready = rst_n && !full;
    assign p_fire  = p_valid && p_ready;
    assign l_fire  = l_valid && l_ready;

    // PIPE wins in GNT_PIPE; GNT_LLU drains the head regardless.
    assign pop  = !empty && ((state == GNT_LLU) || !p_valid);
    assign lose = !empty && !pop;

    // A PIPE write is younger than anything queued for the same register.
    assign kill_en = p_fire && (p_addr != '0);

    always_comb begin
        push_ent          = '0;
        push_ent.live     = !(kill_en && (l_addr == p_addr));
        push_ent.req.addr = l_addr;
        push_ent.req.data = l_data;
    end

    always_comb begin
        gnt = head;
        if (p_fire) begin
            gnt.live     = 1'b1;
            gnt.req.addr = p_addr;
            gnt.req.data = p_data;
        end
    end

    assign gnt_valid = p_fire || pop;
    assign we_nxt    = gnt_valid && gnt.live && (gnt.req.addr != '0);

    rf_wb_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (l_fire),
        .push_ent  (push_ent),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .kill_en   (kill_en),
        .kill_addr (p_addr)
`ifdef RF_WB_PENDMASK_EN
        ,
        .pend_mask (PendMask)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GNT_PIPE;
            starve_cnt <= '0;
            RegWEn     <= 1'b0;
            AddrD      <= '0;
            DataD      <= '0;
        end else begin
            if (lose) begin
                starve_cnt <= (starve_cnt == SMAX) ? SMAX
                                                   : starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end
            unique case (state)
                GNT_PIPE: begin
                    // This loss brings the count up to STARVE_MAX.
                    if (lose && starve_cnt >= SMAX - SW'(1)) begin
                        state <= GNT_LLU;
                    end
                end
                GNT_LLU: state <= GNT_PIPE;
                default: state <= GNT_PIPE;
            endcase
            RegWEn <= we_nxt;
            if (we_nxt) begin
                AddrD <= gnt.req.addr;
                DataD <= gnt.req.data;
            end
        end
    end

endmodule
